// File: rtl/uart_word_sender_if.sv
// -----------------------------------------------------------------------------
// uart_word_sender_if
// Handshake and transmitter-side signal bundle for uart_word_sender.
//   Word_Valid_in / Word_Data_in / Carry_in / Word_Ready_out : upstream word port
//   Tx_DV_out / Tx_Byte_out / Tx_Done_in                      : UART TX stage port
//   Busy_out / Frame_Done_out / Error_out                     : frame status
// Modports: slave  - the sender block (consumes words, drives the TX stage)
//           master - the environment (offers words, models the TX stage)
// -----------------------------------------------------------------------------
interface uart_word_sender_if;
    logic        Word_Valid_in;
    logic [31:0] Word_Data_in;
    logic        Carry_in;
    logic        Word_Ready_out;
    logic        Tx_DV_out;
    logic [7:0]  Tx_Byte_out;
    logic        Tx_Done_in;
    logic        Busy_out;
    logic        Frame_Done_out;
    logic        Error_out;

    modport slave (
        input  Word_Valid_in, Word_Data_in, Carry_in, Tx_Done_in,
        output Word_Ready_out, Tx_DV_out, Tx_Byte_out, Busy_out,
               Frame_Done_out, Error_out
    );

    modport master (
        output Word_Valid_in, Word_Data_in, Carry_in, Tx_Done_in,
        input  Word_Ready_out, Tx_DV_out, Tx_Byte_out, Busy_out,
               Frame_Done_out, Error_out
    );
endinterface

// File: rtl/uart_word_sender.sv
// -----------------------------------------------------------------------------
// uart_word_sender
// Takes a 32-bit adder sum plus carry over a valid/ready handshake and feeds it
// to a UART transmitter as a byte frame:
//   A5(header), D[7:0], D[15:8], D[23:16], D[31:24], {7'b0, carry} [, checksum]
// Each byte is strobed for one cycle on Tx_DV_out; the next byte is issued only
// after the transmitter's one-cycle Tx_Done_in pulse. A per-byte watchdog aborts
// the frame (Error_out pulse) if no done arrives within DONE_TIMEOUT cycles.
//
// Ports:
//   CLK       - clock, rising edge
//   RST_N_in  - asynchronous active-low reset
//   bus       - uart_word_sender_if.slave (word handshake, TX port, status)
//
// Optional feature: define UART_WORD_SENDER_CHECKSUM_EN to append a seventh
// byte holding the XOR of frame bytes 1..5 (header excluded).
// DONE_TIMEOUT is assumed to be at least 2.
// -----------------------------------------------------------------------------
module uart_word_sender #(
    parameter logic [7:0]  HEADER_BYTE  = 8'hA5,
    parameter int unsigned DONE_TIMEOUT = 4096
) (
    input  logic              CLK,
    input  logic              RST_N_in,
    uart_word_sender_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DONE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DONE_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(DONE_TIMEOUT - 1);

`ifdef UART_WORD_SENDER_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd6;
`else
    localparam logic [2:0] LAST_IDX = 3'd5;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

`ifdef UART_WORD_SENDER_CHECKSUM_EN
    // XOR of the four data bytes and the flags byte.
    function automatic logic [7:0] frame_checksum(input logic [31:0] d, input logic c);
        return d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24] ^ {7'b0, c};
    endfunction
`endif

    // Frame byte at position idx for captured word d and carry c.
    function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                              input logic [31:0] d,
                                              input logic c);
        logic [7:0] b;
        case (idx)
            3'd0:    b = HEADER_BYTE;
            3'd1:    b = d[7:0];
            3'd2:    b = d[15:8];
            3'd3:    b = d[23:16];
            3'd4:    b = d[31:24];
            3'd5:    b = {7'b0, c};
`ifdef UART_WORD_SENDER_CHECKSUM_EN
            3'd6:    b = frame_checksum(d, c);
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t           state_q;
    logic [2:0]       idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      data_q;
    logic             carry_q;
    logic             dv_q;
    logic [7:0]       byte_q;
    logic             ready_q;
    logic             busy_q;
    logic             frame_done_q;
    logic             error_q;

    logic [CNT_W-1:0] cnt_d;
    logic             timeout_s;
    logic [2:0]       idx_d;
    logic [7:0]       byte_d;

    // Watchdog increment (saturating) and next-byte lookahead.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Abort on the edge where the counter would reach DONE_TIMEOUT-1; the
        // counter is 0 in the first wait cycle, so Error_out lands exactly
        // DONE_TIMEOUT cycles after the DV cycle.
        timeout_s = (cnt_d == CNT_HIT);
        idx_d     = idx_q + 3'd1;
        byte_d    = frame_byte(idx_d, data_q, carry_q);
    end

    // Frame sequencer with registered outputs.
    always_ff @(posedge CLK or negedge RST_N_in) begin
        if (!RST_N_in) begin
            state_q      <= ST_IDLE;
            idx_q        <= 3'd0;
            cnt_q        <= '0;
            data_q       <= 32'h0000_0000;
            carry_q      <= 1'b0;
            dv_q         <= 1'b0;
            byte_q       <= 8'h00;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            // Strobes default low; each is raised for a single cycle below.
            dv_q         <= 1'b0;
            frame_done_q <= 1'b0;
            error_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.Word_Valid_in && ready_q) begin
                        data_q  <= bus.Word_Data_in;
                        carry_q <= bus.Carry_in;
                        idx_q   <= 3'd0;
                        byte_q  <= HEADER_BYTE;
                        dv_q    <= 1'b1;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_ISSUE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Done takes priority over a coincident timeout.
                    if (bus.Tx_Done_in) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q        <= 3'd0;
                            frame_done_q <= 1'b1;
                            ready_q      <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= ST_IDLE;
                        end else begin
                            idx_q   <= idx_d;
                            byte_q  <= byte_d;
                            dv_q    <= 1'b1;
                            state_q <= ST_ISSUE;
                        end
                    end else if (timeout_s) begin
                        idx_q   <= 3'd0;
                        error_q <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    idx_q   <= 3'd0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.Word_Ready_out = ready_q;
    assign bus.Tx_DV_out      = dv_q;
    assign bus.Tx_Byte_out    = byte_q;
    assign bus.Busy_out       = busy_q;
    assign bus.Frame_Done_out = frame_done_q;
    assign bus.Error_out      = error_q;

endmodule

// File: tb/tb_uart_word_sender.sv
`timescale 1ns/1ps
module tb_uart_word_sender;

    localparam int unsigned TO = 4096;
`ifdef UART_WORD_SENDER_CHECKSUM_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif

    typedef struct {
        logic [31:0]     word;
        logic            carry;
        logic [6:0][7:0] exp;   // exp[0] is the first byte on the wire
    } vec_t;

    vec_t vecs [6];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_word_sender_if bus ();

    uart_word_sender #(
        .HEADER_BYTE  (8'hA5),
        .DONE_TIMEOUT (TO)
    ) dut (
        .CLK      (clk),
        .RST_N_in (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    logic model_en   = 1'b1;
    logic model_done = 1'b0;
    logic spur_done  = 1'b0;
    int   cd         = 0;

    assign bus.Tx_Done_in = model_done | spur_done;

    // Transmitter model: done pulse 10 cycles after each DV strobe.
    always @(negedge clk) begin
        model_done = 1'b0;
        if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0 && model_en) model_done = 1'b1;
        end
        if (bus.Tx_DV_out) cd = 10;
    end

    logic [7:0] rx_q [$];
    int dv_n  = 0;
    int fd_n  = 0;
    int err_n = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor.
    always @(negedge clk) begin
        if (bus.Tx_DV_out) begin
            rx_q.push_back(bus.Tx_Byte_out);
            dv_n++;
        end
        if (bus.Frame_Done_out) fd_n++;
        if (bus.Error_out) err_n++;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input int lim);
        int k;
        k = 0;
        while (!bus.Word_Ready_out && k < lim) begin
            tick();
            k++;
        end
        check("ready_wait", {31'b0, bus.Word_Ready_out}, 32'd1);
    endtask

    task automatic wait_end(input int lim);
        int k;
        k = 0;
        while (!(bus.Frame_Done_out || bus.Error_out) && k < lim) begin
            tick();
            k++;
        end
        check("frame_end_seen", {31'b0, bus.Frame_Done_out | bus.Error_out}, 32'd1);
    endtask

    task automatic compare_bytes(input string nm, input int off, input int vi);
        logic [7:0] got;
        for (int b = 0; b < NB; b++) begin
            if (off + b < rx_q.size()) got = rx_q[off + b];
            else got = 8'hxx;
            check($sformatf("%s_b%0d", nm, b), {24'b0, got}, {24'b0, vecs[vi].exp[b]});
        end
    endtask

    task automatic run_vec(input int vi, input bit spur);
        int b_dv, b_fd, b_err;
        rx_q.delete();
        wait_ready(200);
        b_dv = dv_n; b_fd = fd_n; b_err = err_n;
        bus.Word_Valid_in = 1'b1;
        bus.Word_Data_in  = vecs[vi].word;
        bus.Carry_in      = vecs[vi].carry;
        tick();
        bus.Word_Valid_in = 1'b0;
        check($sformatf("v%0d_hdr_dv", vi), {22'b0, bus.Tx_DV_out, bus.Tx_Byte_out, bus.Busy_out},
              {22'b0, 1'b1, 8'hA5, 1'b1});
        if (spur) begin
            spur_done = 1'b1;   // high across the edge closing the ISSUE cycle
            tick();
            spur_done = 1'b0;
        end
        wait_end(300);
        tick();
        compare_bytes($sformatf("v%0d", vi), 0, vi);
        check($sformatf("v%0d_dv_count", vi), dv_n - b_dv, NB);
        check($sformatf("v%0d_fd_count", vi), fd_n - b_fd, 32'd1);
        check($sformatf("v%0d_err_count", vi), err_n - b_err, 32'd0);
    endtask

    initial begin
        int b_dv, b_fd, b_err, k, t0;

        vecs[0] = '{32'h12345678, 1'b1, {8'h09, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'hA5}};
        vecs[1] = '{32'hFFFFFFFF, 1'b0, {8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hA5}};
        vecs[2] = '{32'h00000001, 1'b1, {8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'hA5}};
        vecs[3] = '{32'h00000000, 1'b0, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5}};
        vecs[4] = '{32'hCAFEBABE, 1'b0, {8'h30, 8'h00, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'hA5}};
        vecs[5] = '{32'hDEADBEEF, 1'b1, {8'h23, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hA5}};

        bus.Word_Valid_in = 1'b0;
        bus.Word_Data_in  = 32'h0;
        bus.Carry_in      = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset_outputs",
              {19'b0, bus.Word_Ready_out, bus.Tx_DV_out, bus.Tx_Byte_out, bus.Busy_out,
               bus.Frame_Done_out, bus.Error_out}, {19'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        rst_n = 1'b1;
        tick();

        // Table-driven frames.
        for (int i = 0; i < 6; i++) run_vec(i, 1'b0);

        // Back-to-back with Word_Valid_in held high.
        rx_q.delete();
        wait_ready(200);
        b_dv = dv_n; b_fd = fd_n;
        bus.Word_Valid_in = 1'b1;
        bus.Word_Data_in  = vecs[1].word;
        bus.Carry_in      = vecs[1].carry;
        tick();
        k = 0;
        while (!bus.Frame_Done_out && k < 300) begin
            tick();
            k++;
        end
        check("b2b_fd_ready", {30'b0, bus.Frame_Done_out, bus.Word_Ready_out}, 32'd3);
        bus.Word_Data_in = vecs[2].word;
        bus.Carry_in     = vecs[2].carry;
        tick();
        check("b2b_second_hdr", {23'b0, bus.Tx_DV_out, bus.Tx_Byte_out}, {23'b0, 1'b1, 8'hA5});
        bus.Word_Valid_in = 1'b0;
        wait_end(300);
        tick();
        compare_bytes("b2b_first", 0, 1);
        compare_bytes("b2b_second", NB, 2);
        check("b2b_dv_count", dv_n - b_dv, 2 * NB);
        check("b2b_fd_count", fd_n - b_fd, 32'd2);

        // Timeout: transmitter never answers.
        model_en = 1'b0;
        rx_q.delete();
        wait_ready(200);
        b_dv = dv_n; b_fd = fd_n; b_err = err_n;
        bus.Word_Valid_in = 1'b1;
        bus.Word_Data_in  = 32'h55AA55AA;
        bus.Carry_in      = 1'b0;
        tick();
        bus.Word_Valid_in = 1'b0;
        t0 = cyc;
        check("to_hdr_dv", {31'b0, bus.Tx_DV_out}, 32'd1);
        k = 0;
        while (!bus.Error_out && k < int'(TO) + 50) begin
            tick();
            k++;
        end
        check("to_error_seen", {31'b0, bus.Error_out}, 32'd1);
        check("to_delay", cyc - t0, TO);
        check("to_ready_busy", {30'b0, bus.Word_Ready_out, bus.Busy_out}, 32'd2);
        repeat (20) tick();
        check("to_dv_count", dv_n - b_dv, 32'd1);
        check("to_err_count", err_n - b_err, 32'd1);
        check("to_fd_count", fd_n - b_fd, 32'd0);
        model_en = 1'b1;

        // Word_Valid_in toggled while busy.
        rx_q.delete();
        wait_ready(200);
        b_dv = dv_n;
        bus.Word_Valid_in = 1'b1;
        bus.Word_Data_in  = vecs[3].word;
        bus.Carry_in      = vecs[3].carry;
        tick();
        bus.Word_Data_in = 32'hDEADBEEF;
        bus.Carry_in     = 1'b1;
        for (int j = 0; j < 30; j++) begin
            bus.Word_Valid_in = j[0];
            tick();
        end
        bus.Word_Valid_in = 1'b0;
        wait_end(300);
        repeat (20) tick();
        compare_bytes("busy_ign", 0, 3);
        check("busy_ign_dv_count", dv_n - b_dv, NB);

        // Reset while waiting on byte 3.
        rx_q.delete();
        wait_ready(200);
        b_dv = dv_n; b_fd = fd_n; b_err = err_n;
        bus.Word_Valid_in = 1'b1;
        bus.Word_Data_in  = vecs[0].word;
        bus.Carry_in      = vecs[0].carry;
        tick();
        bus.Word_Valid_in = 1'b0;
        k = 0;
        while (dv_n - b_dv < 4 && k < 200) begin
            tick();
            k++;
        end
        check("rst_reached_byte3", dv_n - b_dv, 32'd4);
        repeat (3) tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs",
              {19'b0, bus.Word_Ready_out, bus.Tx_DV_out, bus.Tx_Byte_out, bus.Busy_out,
               bus.Frame_Done_out, bus.Error_out}, {19'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (15) tick();
        check("rst_no_pulses", {16'b0, 8'(fd_n - b_fd), 8'(err_n - b_err)}, 32'd0);
        check("rst_no_extra_dv", dv_n - b_dv, 32'd4);
        run_vec(4, 1'b0);

        // Spurious done in IDLE, then in an ISSUE cycle.
        b_dv = dv_n;
        spur_done = 1'b1;
        repeat (3) tick();
        spur_done = 1'b0;
        repeat (2) tick();
        check("spur_idle_no_dv", dv_n - b_dv, 32'd0);
        check("spur_idle_ready", {31'b0, bus.Word_Ready_out}, 32'd1);
        run_vec(5, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_word_sender.md
# uart_word_sender

Upstream feeder for the UART transmitter: accepts a 32-bit adder result plus carry over a valid/ready handshake and serialises it as a fixed byte frame. Each byte is handed to the transmitter with a one-cycle data-valid strobe, and the block waits for the transmitter's one-cycle done pulse before issuing the next byte. It sits between the 32-bit ripple-carry adder result register and the UART TX stage.

## Interface
- HEADER_BYTE, 8'hA5, first byte of every frame
- DONE_TIMEOUT, 4096, max cycles to wait for Tx_Done_in per byte before aborting; must be ≥ 10*CLKS_PER_BIT of the transmitter
- CLK  input  1  clock, all logic on rising edge
- RST_N_in  input  1  reset, asynchronous, active-low
- Word_Valid_in  input  1  result word offered
- Word_Data_in  input  32  adder sum
- Carry_in  input  1  adder carry-out
- Word_Ready_out  output  1  block can accept a word
- Tx_DV_out  output  1  one-cycle strobe to transmitter
- Tx_Byte_out  output  8  byte for transmitter, valid with Tx_DV_out
- Tx_Done_in  input  1  transmitter one-cycle done pulse
- Busy_out  output  1  frame in progress
- Frame_Done_out  output  1  one-cycle pulse, frame fully sent
- Error_out  output  1  one-cycle pulse, frame aborted on timeout

## Operation
- Frame: HEADER_BYTE, D[7:0], D[15:8], D[23:16], D[31:24], {7'b0, carry}; optional checksum byte (see Configuration). Length N = 6 or 7.
- States: IDLE, ISSUE, WAIT_DONE.
- IDLE: Word_Ready_out=1. On Word_Valid_in&&Word_Ready_out, capture data and carry, byte index=0, go to ISSUE.
- ISSUE: Tx_DV_out=1 for exactly this one cycle, Tx_Byte_out=frame[index]. Clear timeout counter. Go to WAIT_DONE.
- WAIT_DONE: Tx_DV_out=0. Tx_Byte_out holds its value.
  - On Tx_Done_in with index<N-1: index++, go to ISSUE.
  - On Tx_Done_in with index=N-1: go to IDLE, pulse Frame_Done_out.
  - Timeout counter reaches DONE_TIMEOUT-1 without done: go to IDLE, pulse Error_out, discard frame.
  - Done and timeout in the same cycle: done wins.
- Tx_Done_in is ignored in IDLE and ISSUE.
- Word_Valid_in is ignored while Busy_out=1. No buffering; upstream must hold the word until accepted.
- Busy_out = (state != IDLE). Word_Ready_out = (state == IDLE).
- Timeout counter width is $clog2(DONE_TIMEOUT+1). It saturates and never wraps.

## Timing
- Reset values: Word_Ready_out=1, Tx_DV_out=0, Tx_Byte_out=8'h00, Busy_out=0, Frame_Done_out=0, Error_out=0, state=IDLE, index=0.
- Reset mid-frame immediately returns to the reset values; the frame is lost and no Frame_Done_out or Error_out pulse is issued.
- Accept edge at cycle T: Tx_DV_out=1 with header in cycle T+1.
- Done seen in cycle K: next DV strobe in cycle K+1.
- Last done in cycle K: Frame_Done_out=1 and Word_Ready_out=1 in cycle K+1, so a new word can be accepted at K+1.
- All outputs are registered.

## Configuration
- Macro UART_WORD_SENDER_CHECKSUM_EN.
  - Defined: N=7. The seventh byte is the XOR of frame bytes 1..5 (data bytes and flags byte, header excluded).
  - Undefined: N=6, no checksum logic.

## Test plan
- Word 0x12345678, carry 1, bench model pulses done 10 cycles after each DV -> bytes A5,78,56,34,12,01 in order (plus 09 with macro); one Frame_Done_out pulse; exactly 6 (7) DV strobes.
- Two words back-to-back with Word_Valid_in held high: 0xFFFFFFFF/0 then 0x00000001/1 -> second accepted in the cycle Frame_Done_out=1; bytes A5,FF,FF,FF,FF,00 then A5,01,00,00,00,01.
- Tx_Done_in never pulses after the header DV -> Error_out pulse exactly DONE_TIMEOUT cycles after the DV cycle; Word_Ready_out=1 the same cycle; no further DV.
- Word_Valid_in toggled with 0xDEADBEEF while busy on 0x00000000 -> ignored; only the 0x00000000 frame is sent.
- RST_N_in low while waiting on byte 3 -> all outputs at reset values asynchronously; after release, a new word 0xCAFEBABE is sent from the header.
- Spurious Tx_Done_in in IDLE and in ISSUE cycles -> no index advance, no extra DV strobes.
